placement_result_collector: RTL and testbench

Downstream capture stage for the rectangle-placement pipeline. It tracks which cycles carried a real rectangle into the placer using a latency-matched valid delay line. When the placed result appears on the placer's index_x_o/index_y_o/strike_o outputs, it tags the result with a sequence number and a strike-increment flag and buffers it in a FIFO. Consumers drain the FIFO through a valid/ready handshake; the placer itself never stalls, so overflow is detected and reported.

---
 rtl/placement_result_collector.sv | 141 ++++++++++++++
 tb/tb_placement_result_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/placement_result_collector.sv
// Capture stage behind the rectangle placer: matches placer latency with a valid
// delay line, tags each placed result with a sequence number and a strike-change flag, and buffers it.
module placement_result_collector #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 8,
    parameter int SEQ_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rect_valid_i,
    input  logic [7:0]               index_x_i,
    input  logic [7:0]               index_y_i,
    input  logic [3:0]               strike_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [7:0]               res_x_o,
    output logic [7:0]               res_y_o,
    output logic [3:0]               res_strike_o,
    output logic                     res_strike_inc_o,
    output logic [SEQ_W-1:0]         res_seq_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

    typedef struct packed {
        logic [7:0]       x;
        logic [7:0]       y;
        logic [3:0]       strike;
        logic             strike_inc;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    logic [LATENCY-1:0] dly_q, dly_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [3:0]         prev_strike_q, prev_strike_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];

    logic   cap_valid;
    logic   empty;
    logic   full;
    logic   push;
    logic   pop;
    entry_t cap_entry;
    entry_t head;

    // Bit LATENCY-1 lines up with the cycle the placer presents the result.
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = rect_valid_i;
        for (int i = 1; i < LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign cap_valid = dly_q[LATENCY-1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && res_ready_i;
    assign push  = cap_valid && (!full || pop);

    always_comb begin
        cap_entry            = '0;
        cap_entry.x          = index_x_i;
        cap_entry.y          = index_y_i;
        cap_entry.strike     = strike_i;
        cap_entry.strike_inc = (strike_i != prev_strike_q);
        cap_entry.seq        = seq_q;
    end

    // Sequence and strike history advance on every capture, dropped or not.
    always_comb begin
        seq_d         = seq_q;
        prev_strike_d = prev_strike_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        overflow_d    = overflow_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (cap_valid) begin
            seq_d         = seq_q + SEQ_ONE;
            prev_strike_d = strike_i;
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = cap_entry;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (cap_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dly_q         <= '0;
            seq_q         <= '0;
            prev_strike_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dly_q         <= dly_d;
            seq_q         <= seq_d;
            prev_strike_q <= prev_strike_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head             = mem_q[rd_ptr_q[AW-1:0]];
    assign res_valid_o      = !empty;
    assign res_x_o          = head.x;
    assign res_y_o          = head.y;
    assign res_strike_o     = head.strike;
    assign res_strike_inc_o = head.strike_inc;
    assign res_seq_o        = head.seq;
    assign count_o          = wr_ptr_q - rd_ptr_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_placement_result_collector.sv
// Directed bench for placement_result_collector; a behavioural placer pipeline
// feeds index/strike values LATENCY cycles after each rectangle is issued.
module tb_placement_result_collector;

    localparam int L  = 8;
    localparam int D  = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rect_valid = 1'b0;
    logic [7:0]    in_x = '0;
    logic [7:0]    in_y = '0;
    logic [3:0]    in_s = '0;
    logic          ready = 1'b0;
    logic [7:0]    index_x;
    logic [7:0]    index_y;
    logic [3:0]    strike;
    logic          res_valid;
    logic [7:0]    res_x;
    logic [7:0]    res_y;
    logic [3:0]    res_strike;
    logic          res_inc;
    logic [SW-1:0] res_seq;
    logic [3:0]    count;
    logic          overflow;

    logic [7:0] px [L] = '{default: '0};
    logic [7:0] py [L] = '{default: '0};
    logic [3:0] ps [L] = '{default: '0};

    int n_cmp  = 0;
    int n_fail = 0;

    placement_result_collector #(.LATENCY(L), .DEPTH(D), .SEQ_W(SW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rect_valid_i(rect_valid),
        .index_x_i(index_x), .index_y_i(index_y), .strike_i(strike),
        .res_valid_o(res_valid), .res_ready_i(ready), .res_x_o(res_x),
        .res_y_o(res_y), .res_strike_o(res_strike), .res_strike_inc_o(res_inc),
        .res_seq_o(res_seq), .count_o(count), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the placer: the payload applied with a rectangle appears L edges later.
    always @(posedge clk) begin
        px[0] <= in_x;
        py[0] <= in_y;
        ps[0] <= in_s;
        for (int i = 1; i < L; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            ps[i] <= ps[i-1];
        end
    end

    assign index_x = px[L-1];
    assign index_y = py[L-1];
    assign strike  = ps[L-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rect_valid = 1'b0;
        ready      = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", res_valid); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        n_cmp++; if ({res_x, res_y, res_strike, res_inc, res_seq} !== 29'd0) begin
            n_fail++; $display("[TB] FAIL reset_head: got x=%0h y=%0h s=%0h i=%0b q=%0h expected all 0", res_x, res_y, res_strike, res_inc, res_seq);
        end
        do_reset();
    endtask

    task automatic test_single();
        int valid_cycles = 0;
        int first = -1;
        do_reset();
        ready = 1'b1;
        in_x = 8'h10; in_y = 8'h03; in_s = 4'd0; rect_valid = 1'b1;
        step();
        rect_valid = 1'b0; in_x = 8'hEE; in_y = 8'hEE; in_s = 4'd9;
        for (int i = 1; i <= L + 6; i++) begin
            step();
            if (res_valid === 1'b1) begin
                valid_cycles++;
                if (first < 0) first = i;
                n_cmp++; if ({res_x, res_y, res_seq, res_inc} !== {8'h10, 8'h03, 8'h00, 1'b0}) begin
                    n_fail++; $display("[TB] FAIL single_head: got x=%0h y=%0h seq=%0d inc=%0b expected 10/03/0/0", res_x, res_y, res_seq, res_inc);
                end
            end
        end
        n_cmp++; if (first !== L) begin n_fail++; $display("[TB] FAIL single_latency: got %0d expected %0d", first, L); end
        n_cmp++; if (valid_cycles !== 1) begin n_fail++; $display("[TB] FAIL single_valid_cycles: got %0d expected 1", valid_cycles); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 0", count); end
    endtask

    task automatic test_burst_overflow();
        int got;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rect_valid = 1'b1; in_x = 8'(i); in_y = 8'(i + 8'h40); in_s = 4'd0;
            step();
        end
        rect_valid = 1'b0;
        for (int i = 0; i < L - 4; i++) step();
        n_cmp++; if ({count, overflow} !== {4'd8, 1'b0}) begin
            n_fail++; $display("[TB] FAIL burst_full_8: got count=%0d ovf=%0b expected 8/0", count, overflow);
        end
        step();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_overflow_9th: got %0b expected 1", overflow); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL burst_saturate: got %0d expected 8", count); end
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({res_valid, res_seq, res_x, res_y} !== {1'b1, 8'(k), 8'(k), 8'(k + 8'h40)}) begin
                n_fail++; $display("[TB] FAIL burst_drain_%0d: got v=%0b seq=%0d x=%0h y=%0h expected 1/%0d/%0h/%0h", k, res_valid, res_seq, res_x, res_y, k, k, k + 8'h40);
            end
            step();
        end
        n_cmp++; if ({res_valid, count} !== {1'b0, 4'd0}) begin
            n_fail++; $display("[TB] FAIL burst_empty: got v=%0b count=%0d expected 0/0", res_valid, count);
        end
        rect_valid = 1'b1; in_x = 8'h77;
        step();
        rect_valid = 1'b0;
        got = -1;
        for (int i = 0; i < L + 4 && got < 0; i++) begin
            step();
            if (res_valid === 1'b1) got = int'(res_seq);
        end
        n_cmp++; if (got !== 12) begin n_fail++; $display("[TB] FAIL burst_next_seq: got %0d expected 12", got); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            rect_valid = 1'b1; in_x = 8'(8'h20 + i); in_y = 8'h01; in_s = 4'd0;
            step();
        end
        rect_valid = 1'b0;
        for (int i = 0; i < L - 1; i++) step();
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL fpp_full: got %0d expected 8", count); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_cmp++; if ({count, overflow, res_seq} !== {4'd8, 1'b0, 8'd1}) begin
            n_fail++; $display("[TB] FAIL fpp_same_cycle: got count=%0d ovf=%0b seq=%0d expected 8/0/1", count, overflow, res_seq);
        end
        step();
        n_cmp++; if ({res_valid, res_seq, res_x} !== {1'b1, 8'd1, 8'h21}) begin
            n_fail++; $display("[TB] FAIL fpp_hold: got v=%0b seq=%0d x=%0h expected 1/1/21", res_valid, res_seq, res_x);
        end
        ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n_cmp++; if ({res_seq, res_x} !== {8'(k), 8'(8'h20 + k)}) begin
                n_fail++; $display("[TB] FAIL fpp_drain_%0d: got seq=%0d x=%0h expected %0d/%0h", k, res_seq, res_x, k, 8'h20 + k);
            end
            step();
        end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL fpp_empty: got %0d expected 0", count); end
    endtask

    task automatic test_strike();
        logic [3:0] st [7];
        logic       ex [7];
        int         n = 0;
        st = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd15, 4'd0};
        ex = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 7 + L + 6; i++) begin
            rect_valid = (i < 7);
            in_s = (i < 7) ? st[i] : 4'd5;
            step();
            if (res_valid === 1'b1 && n < 7) begin
                n_cmp++; if ({res_strike, res_inc} !== {st[n], ex[n]}) begin
                    n_fail++; $display("[TB] FAIL strike_%0d: got s=%0d inc=%0b expected %0d/%0b", n, res_strike, res_inc, st[n], ex[n]);
                end
                n++;
            end
        end
        n_cmp++; if (n !== 7) begin n_fail++; $display("[TB] FAIL strike_count: got %0d expected 7", n); end
    endtask

    task automatic test_reset_midflight();
        int late = 0;
        int got = -1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rect_valid = 1'b1; in_x = 8'h55; step();
        end
        rect_valid = 1'b0;
        for (int i = 0; i < L - 3; i++) step();
        for (int i = 0; i < 3; i++) begin
            rect_valid = 1'b1; step();
        end
        rect_valid = 1'b0;
        n_cmp++; if (count !== 4'd4) begin n_fail++; $display("[TB] FAIL mid_buffered: got %0d expected 4", count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({res_valid, count, res_x, res_seq} !== 21'd0) begin
            n_fail++; $display("[TB] FAIL mid_reset_outputs: got v=%0b count=%0d x=%0h seq=%0d expected 0", res_valid, count, res_x, res_seq);
        end
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 2 * L; i++) begin
            step();
            if (res_valid === 1'b1) late++;
        end
        n_cmp++; if (late !== 0) begin n_fail++; $display("[TB] FAIL mid_late_results: got %0d expected 0", late); end
        rect_valid = 1'b1; step(); rect_valid = 1'b0;
        for (int i = 0; i < L + 4 && got < 0; i++) begin
            step();
            if (res_valid === 1'b1) got = int'(res_seq);
        end
        n_cmp++; if (got !== 0) begin n_fail++; $display("[TB] FAIL mid_first_seq: got %0d expected 0", got); end
    endtask

    task automatic test_seq_wrap();
        int n = 0;
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 260 + L + 6; i++) begin
            rect_valid = (i < 260);
            step();
            if (res_valid === 1'b1) begin
                n_cmp++; if (res_seq !== 8'(n % 256)) begin
                    n_fail++; $display("[TB] FAIL wrap_seq_%0d: got %0d expected %0d", n, res_seq, n % 256);
                end
                n++;
            end
        end
        rect_valid = 1'b0;
        n_cmp++; if (n !== 260) begin n_fail++; $display("[TB] FAIL wrap_total: got %0d expected 260", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_full_pop_push();
        test_strike();
        test_reset_midflight();
        test_seq_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
